// File: rtl/lut_test_pkg.sv
// rtl/lut_test_pkg.sv - shared state type and truth-table helpers for the LUT sweep checker
package lut_test_pkg;

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} sweep_state_t;

   // Widest truth table supported: 4 outputs x 2^8 vectors.
   localparam int MAX_INIT_W = 4 * 256;

   function automatic int err_count_width(input int k);
      return k + 1;
   endfunction

   function automatic logic expected_bit(input logic [MAX_INIT_W-1:0] init, input int k,
                                         input int j, input int v);
      logic [9:0] idx;
      idx = 10'((j << k) + v);
      return init[idx];
   endfunction

endpackage

// File: rtl/lut_sync_stage.sv
// rtl/lut_sync_stage.sv - multi-bit flop chain bringing the LUT outputs into the clk domain
module lut_sync_stage #(
   parameter int NUM_OUT     = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_OUT-1:0] d,
   output logic [NUM_OUT-1:0] q
);

   logic [NUM_OUT-1:0] stage_q [SYNC_STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/lut_sweep_checker.sv
// rtl/lut_sweep_checker.sv - exhaustive stimulus and truth-table check of a K-input LUT
module lut_sweep_checker
   import lut_test_pkg::*;
#(
   parameter int                              LUT_K         = 4,
   parameter int                              NUM_OUT       = 1,
   parameter logic [NUM_OUT*(2**LUT_K)-1:0]   INIT          = '0,
   parameter int                              SETTLE_CYCLES = 4,
   parameter int                              SYNC_STAGES   = 2,
   parameter bit                              STOP_ON_FAIL  = 1'b0
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   output logic [LUT_K-1:0]                     lut_in,
   input  logic [NUM_OUT-1:0]                   lut_out,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 pass,
   output logic [err_count_width(LUT_K)-1:0]    err_count,
   output logic                                 first_fail_valid,
   output logic [LUT_K-1:0]                     first_fail_vec
);

   localparam int                    CNT_W       = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0]      SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
   localparam logic [LUT_K-1:0]      LAST_VEC    = '1;
   localparam logic [MAX_INIT_W-1:0] INIT_EXT    = MAX_INIT_W'(INIT);

   sweep_state_t       state;
   logic [CNT_W-1:0]   settle_cnt;
   logic [NUM_OUT-1:0] synced;
   logic [NUM_OUT-1:0] expected;
   logic               mismatch;

   lut_sync_stage #(
      .NUM_OUT     (NUM_OUT),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (lut_out),
      .q     (synced)
   );

   always_comb begin
      expected = '0;
      for (int j = 0; j < NUM_OUT; j++)
         expected[j] = expected_bit(INIT_EXT, LUT_K, j, int'(lut_in));
   end

   // Case inequality so an undriven or X output from the DUT is reported as a failure.
   assign mismatch = (synced !== expected);

   // lut_in doubles as the vector counter; it only moves on entry to SETTLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         settle_cnt       <= '0;
         lut_in           <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_count        <= '0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state            <= SETTLE;
                  settle_cnt       <= SETTLE_LOAD;
                  lut_in           <= '0;
                  busy             <= 1'b1;
                  done             <= 1'b0;
                  pass             <= 1'b0;
                  err_count        <= '0;
                  first_fail_valid <= 1'b0;
                  first_fail_vec   <= '0;
               end
            end
            SETTLE: begin
               settle_cnt <= settle_cnt - CNT_ONE;
               if (settle_cnt == CNT_ONE) state <= CHECK;
            end
            CHECK: begin
               if (mismatch) begin
                  err_count <= err_count + 1'b1;
                  if (!first_fail_valid) begin
                     first_fail_valid <= 1'b1;
                     first_fail_vec   <= lut_in;
                  end
               end
               if (lut_in == LAST_VEC || (STOP_ON_FAIL && mismatch)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == '0) && !mismatch;
               end else begin
                  state      <= SETTLE;
                  settle_cnt <= SETTLE_LOAD;
                  lut_in     <= lut_in + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lut_sweep_checker.sv
// tb/tb_lut_sweep_checker.sv - randomized self-checking bench for lut_sweep_checker
module tb_lut_sweep_checker;

   localparam logic [15:0]  INIT_A = 16'hFF5E;
   localparam logic [127:0] INIT_C = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
   localparam int KK  [3] = '{4, 4, 6};
   localparam int SS  [3] = '{4, 4, 3};
   localparam int STP [3] = '{0, 1, 0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] rstn  = '0;
   logic [2:0] start = '0;
   logic [1:0] flt  [3][256];
   logic [1:0] mflt [3][256];
   int checks   = 0;
   int failures = 0;
   int tm [3]   = '{-1, -1, -1};

   logic [3:0] lin_a, lin_b, ffvec_a, ffvec_b;
   logic [5:0] lin_c, ffvec_c;
   logic [4:0] err_a, err_b;
   logic [6:0] err_c;
   logic       lout_a, lout_b;
   logic [1:0] lout_c;
   logic busy_a, done_a, pass_a, ffv_a;
   logic busy_b, done_b, pass_b, ffv_b;
   logic busy_c, done_c, pass_c, ffv_c;

   // Device under check: the truth table itself with optional bit flips per vector.
   always_comb begin
      lout_a    = INIT_A[lin_a] ^ flt[0][lin_a][0];
      lout_b    = INIT_A[lin_b] ^ flt[1][lin_b][0];
      lout_c[0] = INIT_C[{1'b0, lin_c}] ^ flt[2][lin_c][0];
      lout_c[1] = INIT_C[{1'b1, lin_c}] ^ flt[2][lin_c][1];
   end

   lut_sweep_checker #(.LUT_K(4), .NUM_OUT(1), .INIT(INIT_A), .SETTLE_CYCLES(4),
                       .SYNC_STAGES(2), .STOP_ON_FAIL(1'b0)) u_a (
      .clk(clk), .rst_n(rstn[0]), .start(start[0]), .lut_in(lin_a), .lut_out(lout_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
      .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a));

   lut_sweep_checker #(.LUT_K(4), .NUM_OUT(1), .INIT(INIT_A), .SETTLE_CYCLES(4),
                       .SYNC_STAGES(2), .STOP_ON_FAIL(1'b1)) u_b (
      .clk(clk), .rst_n(rstn[1]), .start(start[1]), .lut_in(lin_b), .lut_out(lout_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
      .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b));

   lut_sweep_checker #(.LUT_K(6), .NUM_OUT(2), .INIT(INIT_C), .SETTLE_CYCLES(3),
                       .SYNC_STAGES(2), .STOP_ON_FAIL(1'b0)) u_c (
      .clk(clk), .rst_n(rstn[2]), .start(start[2]), .lut_in(lin_c), .lut_out(lout_c),
      .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
      .first_fail_valid(ffv_c), .first_fail_vec(ffvec_c));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic int pack(input int b, input int d, input int p, input int fv,
                               input int e, input int fvec, input int li);
      return li | (fvec << 8) | (e << 16) | (fv << 25) | (p << 26) | (d << 27) | (b << 28);
   endfunction

   function automatic bit is_fail(input int d, input int v);
      return (mflt[d][v] & ((d == 2) ? 2'b11 : 2'b01)) != 2'b00;
   endfunction

   // Expected outputs t clocks after the sampled start: vector v is checked at clock (v+1)*(S+1).
   function automatic void model(input int d, input int t, output int e_pk, output bit e_done);
      int per, vlast, c, li, e, fv, fvec, b;
      e_pk = 0;
      e_done = 1'b0;
      if (t < 0) return;
      per   = SS[d] + 1;
      vlast = (1 << KK[d]) - 1;
      if (STP[d] != 0)
         for (int v = 0; v < (1 << KK[d]); v++)
            if (is_fail(d, v)) begin vlast = v; break; end
      c  = t / per;
      li = (c > vlast) ? vlast : c;
      if (c > vlast + 1) c = vlast + 1;
      e = 0; fv = 0; fvec = 0;
      for (int v = 0; v < c; v++)
         if (is_fail(d, v)) begin
            if (fv == 0) begin fv = 1; fvec = v; end
            e++;
         end
      b      = (t < (vlast + 1) * per) ? 1 : 0;
      e_done = (b == 0);
      e_pk   = pack(b, 1 - b, (b == 0 && e == 0) ? 1 : 0, fv, e, fvec, li);
   endfunction

   function automatic int actual(input int d);
      case (d)
         0: return pack(int'(busy_a), int'(done_a), int'(pass_a), int'(ffv_a),
                        int'(err_a), int'(ffvec_a), int'(lin_a));
         1: return pack(int'(busy_b), int'(done_b), int'(pass_b), int'(ffv_b),
                        int'(err_b), int'(ffvec_b), int'(lin_b));
         default: return pack(int'(busy_c), int'(done_c), int'(pass_c), int'(ffv_c),
                              int'(err_c), int'(ffvec_c), int'(lin_c));
      endcase
   endfunction

   function automatic bit done_of(input int d);
      return (d == 0) ? done_a : (d == 1) ? done_b : done_c;
   endfunction

   int  cmp_pk;
   bit  cmp_done;
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         model(d, tm[d], cmp_pk, cmp_done);
         if (!rstn[d]) tm[d] = -1;
         else if (start[d] && (tm[d] < 0 || cmp_done)) begin
            tm[d] = 0;
            for (int v = 0; v < 256; v++) mflt[d][v] = flt[d][v];
         end else if (tm[d] >= 0) tm[d]++;
      end
      #2;
      for (int d = 0; d < 3; d++) begin
         if (!rstn[d]) tm[d] = -1;
         model(d, tm[d], cmp_pk, cmp_done);
         chk($sformatf("cycle_d%0d_t%0d", d, tm[d]), actual(d), cmp_pk);
      end
   end

   task automatic go(input int d);
      start[d] = 1'b1;
      @(posedge clk);
      #1 start[d] = 1'b0;
   endtask

   task automatic wait_done(input int d, input int bound, input bit repulse, output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1 n++;
         start[d] = repulse && (n == 10 || n == 50);
      end while (!done_of(d) && n < bound);
      start[d] = 1'b0;
      if (!done_of(d)) chk($sformatf("wait_done_timeout_d%0d", d), 0, 1);
   endtask

   int n;
   initial begin
      for (int d = 0; d < 3; d++)
         for (int v = 0; v < 256; v++) begin flt[d][v] = 2'b00; mflt[d][v] = 2'b00; end
      repeat (3) @(posedge clk);
      #1 rstn = '1;
      chk("reset_busy", int'(busy_a), 0);
      chk("reset_done", int'(done_a), 0);
      chk("reset_err", int'(err_a), 0);
      chk("reset_lut_in", int'(lin_a), 0);

      go(0);
      wait_done(0, 400, 1'b1, n);
      chk("a_golden_latency", n, 80);
      chk("a_golden_pass", int'(pass_a), 1);
      chk("a_golden_err", int'(err_a), 0);
      chk("a_golden_ffv", int'(ffv_a), 0);

      flt[0][5] = 2'b01;
      go(0);
      chk("a_restart_done_drops", int'(done_a), 0);
      wait_done(0, 400, 1'b0, n);
      chk("a_fault5_latency", n, 80);
      chk("a_fault5_pass", int'(pass_a), 0);
      chk("a_fault5_err", int'(err_a), 1);
      chk("a_fault5_ffvec", int'(ffvec_a), 5);

      go(0);
      repeat (37) @(posedge clk);
      #1 rstn[0] = 1'b0;
      #2;
      chk("a_midreset_busy", int'(busy_a), 0);
      chk("a_midreset_err", int'(err_a), 0);
      chk("a_midreset_lut_in", int'(lin_a), 0);
      chk("a_midreset_ffv", int'(ffv_a), 0);
      @(posedge clk);
      #1 rstn[0] = 1'b1;
      flt[0][5] = 2'b00;
      go(0);
      wait_done(0, 400, 1'b0, n);
      chk("a_after_reset_latency", n, 80);
      chk("a_after_reset_pass", int'(pass_a), 1);

      flt[1][3] = 2'b01;
      flt[1][9] = 2'b01;
      go(1);
      wait_done(1, 400, 1'b0, n);
      chk("b_stop_latency", n, 20);
      chk("b_stop_err", int'(err_b), 1);
      chk("b_stop_ffvec", int'(ffvec_b), 3);
      chk("b_stop_lut_in", int'(lin_b), 3);

      go(2);
      wait_done(2, 1000, 1'b0, n);
      chk("c_golden_latency", n, 256);
      chk("c_golden_pass", int'(pass_c), 1);
      flt[2][63] = 2'b10;
      go(2);
      wait_done(2, 1000, 1'b0, n);
      chk("c_fault63_err", int'(err_c), 1);
      chk("c_fault63_ffvec", int'(ffvec_c), 63);
      chk("c_fault63_pass", int'(pass_c), 0);

      for (int r = 0; r < 6; r++) begin
         rstn = '0;
         @(posedge clk);
         #1;
         for (int d = 0; d < 3; d++)
            for (int v = 0; v < 256; v++)
               flt[d][v] = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rstn  = '1;
         start = '1;
         @(posedge clk);
         #1 start = '0;
         for (int c = 0; c < 1100; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
               start[d] = ($urandom_range(0, 299) == 0);
               rstn[d]  = ($urandom_range(0, 799) != 0);
            end
         end
         start = '0;
         rstn  = '1;
      end

      @(posedge clk);
      #3 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
